sram_1r1w_masked: RTL and testbench

//   Parametrised single-clock 1-read/1-write register-file memory: successor to the fixed 1R1W ext memories.

---
 rtl/sram_1r1w_masked.sv | 140 ++++++++++++++
 tb/tb_sram_1r1w_masked.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_masked.sv
// 1R1W register-file memory with per-granule write mask and valid bits, one-cycle flush,
// selectable read latency (1/2) and selectable read-during-write policy.
module sram_1r1w_masked #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 11,
  parameter int unsigned MASK_W   = 1,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_valid
);

  localparam int unsigned GRAN_W = DATA_W / MASK_W;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam longint unsigned ADDR_SPAN = 64'(1) << ADDR_W;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $fatal(1, "sram_1r1w_masked: RD_LAT must be 1 or 2");
  end
  if ((DATA_W % MASK_W) != 0) begin : g_bad_mask
    $fatal(1, "sram_1r1w_masked: DATA_W must be a multiple of MASK_W");
  end
  if (ADDR_SPAN < 64'(DEPTH)) begin : g_bad_addr
    $fatal(1, "sram_1r1w_masked: ADDR_W too narrow for DEPTH");
  end

  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [MASK_W-1:0] r_vld [DEPTH];

  logic              w_wr_ok;
  logic              w_rd_in_range;
  logic              w_same_addr;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_value;

  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_valid;

  assign w_wr_ok       = W0_en && (64'(W0_addr) < 64'(DEPTH));
  assign w_rd_in_range = (64'(R0_addr) < 64'(DEPTH));
  assign w_same_addr   = w_wr_ok && (W0_addr == R0_addr);
  assign w_wr_idx      = IDX_W'(W0_addr);
  assign w_rd_idx      = IDX_W'(R0_addr);

  // Read value as seen in the request cycle; unwritten granules read as zero.
  always_comb begin
    w_rd_value = '0;
    if (w_rd_in_range) begin
      for (int g = 0; g < int'(MASK_W); g++) begin
        if (RDW_MODE == 1 && w_same_addr && W0_mask[g]) begin
          w_rd_value[g*GRAN_W +: GRAN_W] = W0_data[g*GRAN_W +: GRAN_W];
        end else if (r_vld[w_rd_idx][g]) begin
          w_rd_value[g*GRAN_W +: GRAN_W] = r_ram[w_rd_idx][g*GRAN_W +: GRAN_W];
        end
      end
    end
  end

  // Storage is deliberately left uncleared by reset; the valid bits hide stale contents.
  always_ff @(posedge clock) begin
    if (!reset && w_wr_ok) begin
      for (int g = 0; g < int'(MASK_W); g++) begin
        if (W0_mask[g]) begin
          r_ram[w_wr_idx][g*GRAN_W +: GRAN_W] <= W0_data[g*GRAN_W +: GRAN_W];
        end
      end
    end
  end

  // Granule-valid bits; the write is applied after the flush so it wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_vld[i] <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_vld[i] <= '0;
        end
      end
      if (w_wr_ok) begin
        for (int g = 0; g < int'(MASK_W); g++) begin
          if (W0_mask[g]) begin
            r_vld[w_wr_idx][g] <= 1'b1;
          end
        end
      end
    end
  end

  // First read stage: data only captured on a request so the output holds between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= R0_en;
      if (R0_en) begin
        r_s1_data <= w_rd_value;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_valid;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign R0_data  = r_s2_data;
    assign R0_valid = r_s2_valid;
  end else begin : g_lat1
    assign R0_data  = r_s1_data;
    assign R0_valid = r_s1_valid;
  end

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Bench for sram_1r1w_masked: four instances (RD_LAT 1/2 x RDW_MODE 0/1) share one stimulus
// stream and are compared every cycle against a cycle-indexed reference model.
module tb_sram_1r1w_masked;
  localparam int DEPTH = 6;
  localparam int NCYC  = 2048;

  logic        clock = 1'b0;
  logic        reset;
  logic        W0_en;
  logic [2:0]  W0_addr;
  logic [15:0] W0_data;
  logic [1:0]  W0_mask;
  logic        R0_en;
  logic [2:0]  R0_addr;
  logic        flush;
  logic [15:0] o_data  [4];
  logic        o_valid [4];

  always #5 clock = ~clock;

  // Instance k: RD_LAT = k/2 + 1, RDW_MODE = k % 2.
  for (genvar k = 0; k < 4; k++) begin : g_dut
    sram_1r1w_masked #(
      .DEPTH(6), .ADDR_W(3), .DATA_W(16), .MASK_W(2),
      .RD_LAT(k / 2 + 1), .RDW_MODE(k % 2)
    ) u_dut (
      .clock(clock), .reset(reset),
      .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
      .R0_en(R0_en), .R0_addr(R0_addr), .flush(flush),
      .R0_data(o_data[k]), .R0_valid(o_valid[k])
    );
  end

  logic [15:0] m_mem [DEPTH];
  logic [1:0]  m_vld [DEPTH];
  bit          h_ren [NCYC];
  bit          h_rst [NCYC];
  logic [15:0] h_val [2][NCYC];
  logic [15:0] hold  [4];
  int          n_edge;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  function automatic logic [15:0] ref_read(input int mode);
    logic [15:0] v;
    v = 16'h0000;
    if (int'(R0_addr) < DEPTH) begin
      for (int g = 0; g < 2; g++) begin
        if (mode == 1 && W0_en && W0_addr == R0_addr && W0_mask[g])
          v[g*8 +: 8] = W0_data[g*8 +: 8];
        else if (m_vld[R0_addr][g])
          v[g*8 +: 8] = m_mem[R0_addr][g*8 +: 8];
      end
    end
    return v;
  endfunction

  // One clock: record the request against pre-edge state, update the model, then compare.
  task automatic cycle();
    int  n;
    int  lat;
    int  src;
    bit  exp_v;
    n = n_edge;
    if (n >= NCYC) begin
      $display("FAIL cycle_budget: got %0d expected <%0d", n, NCYC);
      $fatal(1, "cycle budget exceeded");
    end
    h_rst[n]    = reset;
    h_ren[n]    = !reset && R0_en;
    h_val[0][n] = ref_read(0);
    h_val[1][n] = ref_read(1);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 2'b00;
    end else begin
      if (flush) for (int i = 0; i < DEPTH; i++) m_vld[i] = 2'b00;
      if (W0_en && int'(W0_addr) < DEPTH) begin
        for (int g = 0; g < 2; g++) begin
          if (W0_mask[g]) begin
            m_mem[W0_addr][g*8 +: 8] = W0_data[g*8 +: 8];
            m_vld[W0_addr][g] = 1'b1;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      lat   = k / 2 + 1;
      src   = n - lat + 1;
      exp_v = 1'b0;
      if (h_rst[n]) begin
        hold[k] = 16'h0000;
      end else if (src >= 0 && h_ren[src]) begin
        exp_v   = 1'b1;
        hold[k] = h_val[k % 2][src];
      end
      check($sformatf("valid_i%0d", k), 32'(o_valid[k]), 32'(exp_v));
      check($sformatf("data_i%0d", k), 32'(o_data[k]), 32'(hold[k]));
    end
    n_edge++;
  endtask

  task automatic drv(input bit we, input int wa, input logic [15:0] wd, input logic [1:0] wm,
                     input bit re, input int ra, input bit fl, input bit rs);
    W0_en = we; W0_addr = 3'(wa); W0_data = wd; W0_mask = wm;
    R0_en = re; R0_addr = 3'(ra); flush = fl; reset = rs;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 16'h0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    n_edge = 0; n_checks = 0; n_fail = 0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 16'h0; m_vld[i] = 2'b00; end
    for (int k = 0; k < 4; k++) hold[k] = 16'h0;

    drv(0, 0, 16'h0, 2'b00, 0, 0, 0, 1);
    drv(1, 2, 16'h7777, 2'b11, 1, 2, 1, 1);
    for (int k = 0; k < 4; k++) check("reset_valid", 32'(o_valid[k]), 32'd0);
    idle(1);

    // Never-written entry reads zero
    drv(0, 0, 16'h0, 2'b00, 1, 2, 0, 0);
    check("unwritten_rd", 32'(o_data[0]), 32'h0000);
    check("unwritten_vld", 32'(o_valid[0]), 32'd1);

    // Granule masked writes
    drv(1, 2, 16'hABCD, 2'b01, 0, 0, 0, 0);
    drv(0, 0, 16'h0, 2'b00, 1, 2, 0, 0);
    check("mask_lo", 32'(o_data[0]), 32'h00CD);
    drv(1, 2, 16'h1200, 2'b10, 0, 0, 0, 0);
    drv(0, 0, 16'h0, 2'b00, 1, 2, 0, 0);
    check("mask_hi", 32'(o_data[0]), 32'h12CD);

    // Read-during-write policies
    drv(1, 4, 16'h1111, 2'b11, 0, 0, 0, 0);
    drv(1, 4, 16'h2222, 2'b10, 1, 4, 0, 0);
    check("rdw_bypass", 32'(o_data[1]), 32'h2211);
    check("rdw_old", 32'(o_data[0]), 32'h1111);
    drv(0, 0, 16'h0, 2'b00, 1, 4, 0, 0);
    check("rdw_after", 32'(o_data[0]), 32'h2211);

    // Flush with same-cycle write, then out-of-range access
    for (int a = 0; a < DEPTH; a++) drv(1, a, 16'h00A0 + 16'(a), 2'b11, 0, 0, 0, 0);
    drv(1, 1, 16'h5555, 2'b11, 0, 0, 1, 0);
    for (int a = 0; a < DEPTH; a++) begin
      drv(0, 0, 16'h0, 2'b00, 1, a, 0, 0);
      check($sformatf("flush_a%0d", a), 32'(o_data[0]), (a == 1) ? 32'h5555 : 32'h0000);
    end
    drv(1, 7, 16'hBEEF, 2'b11, 0, 0, 0, 0);
    drv(0, 0, 16'h0, 2'b00, 1, 7, 0, 0);
    check("oor_rd", 32'(o_data[0]), 32'h0000);

    // Latency-2 back-to-back reads and data hold
    drv(1, 0, 16'h0A0A, 2'b11, 0, 0, 0, 0);
    drv(1, 2, 16'h2B2B, 2'b11, 0, 0, 0, 0);
    drv(0, 0, 16'h0, 2'b00, 1, 0, 0, 0);
    check("lat2_t1_vld", 32'(o_valid[2]), 32'd0);
    drv(0, 0, 16'h0, 2'b00, 1, 1, 0, 0);
    check("lat2_a0", 32'(o_data[2]), 32'h0A0A);
    drv(0, 0, 16'h0, 2'b00, 1, 2, 0, 0);
    check("lat2_a1", 32'(o_data[2]), 32'h5555);
    idle(1);
    check("lat2_a2", 32'(o_data[2]), 32'h2B2B);
    check("lat2_a2_vld", 32'(o_valid[2]), 32'd1);
    drv(1, 2, 16'hFFFF, 2'b11, 0, 0, 0, 0);
    idle(2);
    check("lat2_hold", 32'(o_data[2]), 32'h2B2B);
    check("lat2_hold_vld", 32'(o_valid[2]), 32'd0);

    // Reset drops an in-flight read and hides retained storage
    drv(0, 0, 16'h0, 2'b00, 1, 4, 0, 0);
    drv(0, 0, 16'h0, 2'b00, 1, 4, 0, 1);
    for (int k = 0; k < 4; k++) begin
      check("rst_drop_vld", 32'(o_valid[k]), 32'd0);
      check("rst_data", 32'(o_data[k]), 32'h0000);
    end
    idle(1);
    drv(0, 0, 16'h0, 2'b00, 1, 2, 0, 0);
    check("rst_unreadable", 32'(o_data[0]), 32'h0000);
    idle(2);

    // Randomized traffic with occasional flush/reset and forced address collisions
    for (int i = 0; i < 400; i++) begin
      int wa;
      int ra;
      wa = int'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7));
      drv(bit'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), ra,
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
